// File: rtl/valve_sequencer_pkg.sv
// Shared types and defaults for the valve sequencer and its downstream demux.
package valve_sequencer_pkg;

  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned CH_W           = 2;
  localparam int unsigned DEF_CNT_W      = 24;
  localparam int unsigned DEF_GAP_CYCLES = 16;
  localparam int unsigned DEF_DUR_CYCLES = 1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/valve_sequencer_next_ch_finder.sv
// Masked priority encoder: lowest eligible channel above cur, and lowest overall.
module next_ch_finder
  import valve_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] elig,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   next_ch,
  output logic              found,
  output logic [CH_W-1:0]   first_ch
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    next_ch  = '0;
    found    = 1'b0;
    first_ch = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (elig[i-1]) begin
        first_ch = CH_W'(i - 1);
        if ((i - 1) > 32'(cur)) begin
          next_ch = CH_W'(i - 1);
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/valve_sequencer.sv
// Timed valve sequencer: opens enabled channels in ascending order with a
// closed gap between them; registered outputs feed the 4-way valve demux.
module valve_sequencer
  import valve_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned DEF_DUR    = DEF_DUR_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             loop_en,
  input  logic [3:0]       ch_mask,
  input  logic             dur_wr,
  input  logic [1:0]       dur_addr,
  input  logic [CNT_W-1:0] dur_data,
  output logic [3:0]       sel_out,
  output logic             en_out,
  output logic             valve_out,
  output logic [1:0]       cur_ch,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state, state_n;
  logic [CH_W-1:0]   ch, ch_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [NUM_CH-1:0] mask_q, mask_n;
  logic [CNT_W-1:0]  dur [NUM_CH];
  logic [NUM_CH-1:0] use_mask, elig;
  logic [CH_W-1:0]   nxt_ch, first_ch;
  logic              nxt_found, any_elig;

  // Duration registers; the running count is separate, so rewriting the open channel only affects its next entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) dur[i] <= CNT_W'(DEF_DUR);
    end else if (dur_wr) begin
      dur[dur_addr] <= dur_data;
    end
  end

  // Eligibility: live mask while idle (start decision), latched mask once running.
  always_comb begin
    use_mask = (state == IDLE) ? ch_mask : mask_q;
    for (int unsigned i = 0; i < NUM_CH; i++) elig[i] = use_mask[i] && (dur[i] != '0);
    any_elig = |elig;
  end

  next_ch_finder u_finder (
    .elig     (elig),
    .cur      (ch),
    .next_ch  (nxt_ch),
    .found    (nxt_found),
    .first_ch (first_ch)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ch     <= '0;
      cnt    <= '0;
      mask_q <= '0;
    end else begin
      state  <= state_n;
      ch     <= ch_n;
      cnt    <= cnt_n;
      mask_q <= mask_n;
    end
  end

  // Next-state logic; abort outranks everything outside IDLE.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    cnt_n   = cnt;
    mask_n  = mask_q;
    if (abort && (state != IDLE)) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            mask_n = ch_mask;
            if (any_elig) begin
              state_n = OPEN;
              ch_n    = first_ch;
              cnt_n   = dur[first_ch];
            end else begin
              state_n = DONE;
            end
          end
        end
        OPEN: begin
          if (cnt == CNT_ONE) begin
            state_n = GAP;
            cnt_n   = GAP_LOAD;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt == CNT_ONE) begin
            if (nxt_found) begin
              state_n = OPEN;
              ch_n    = nxt_ch;
              cnt_n   = dur[nxt_ch];
            end else if (loop_en && any_elig) begin
              state_n = OPEN;
              ch_n    = first_ch;
              cnt_n   = dur[first_ch];
            end else begin
              state_n = DONE;
            end
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Registered demux drive decoded from the current state; abort forces the valve shut at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_out   <= '0;
      cur_ch    <= '0;
      en_out    <= 1'b0;
      valve_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sel_out <= {{(4 - CH_W){1'b0}}, ch};
      cur_ch  <= ch;
      if (abort && (state != IDLE)) begin
        en_out    <= 1'b0;
        valve_out <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        valve_out <= (state == OPEN);
        en_out    <= (state == OPEN) || (state == GAP);
        busy      <= (state == OPEN) || (state == GAP);
        done      <= (state == DONE);
      end
    end
  end

endmodule
